// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq -- registered ALU control decoder and RV32M op sequencer.
//
// Decodes ALUOp/funct3/funct7 into the 4-bit ALU control word {inverse,
// function}, carries a destination tag with each op, and holds the pipeline
// (in_ready=0) while a multi-cycle multiply or divide is in flight.
//
// Build option: define MULDIV_EN to enable M-extension sequencing
// (pipelined multiplier wait and divider start/done handshake). Without it,
// funct7=0000001 decodes as an illegal plain ALU op and the divider
// handshake outputs are tied low.
//
// Parameters:
//   MUL_LAT  multiplier latency, accept edge to out_valid (1..15)
//   TAG_W    width of the pass-through destination tag
//
// Ports:
//   clk, rst                synchronous active-high reset
//   in_valid / in_ready     input handshake (accept = in_valid & in_ready)
//   aluop, funct3, funct7   instruction fields to decode
//   is_imm                  I-type arithmetic
//   tag_in / tag_out        destination tag in / on the output
//   flush                   kills the pending op, returns to IDLE
//   out_valid / out_ready   output handshake
//   alu_ctrl, unit_sel,     decoded control word, unit select (00 ALU,
//   md_op, illegal          01 MUL, 10 DIV), M funct3, undefined encoding
//   div_start / div_done    divider handshake
//   div_abort               one-cycle divider cancel pulse
module alu_ctrl_seq #(
  parameter int MUL_LAT = 3,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       aluop,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             is_imm,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_ctrl,
  output logic [1:0]       unit_sel,
  output logic [2:0]       md_op,
  output logic             illegal,
  output logic [TAG_W-1:0] tag_out,
  output logic             div_start,
  input  logic             div_done,
  output logic             div_abort
);

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2,
    OUT      = 2'd3
  } state_t;

  state_t           state_reg;
  logic             out_valid_reg;
  logic [3:0]       alu_ctrl_reg;
  logic [1:0]       unit_sel_reg;
  logic [2:0]       md_op_reg;
  logic             illegal_reg;
  logic [TAG_W-1:0] tag_out_reg;

  logic [3:0]       dec_alu;
  logic [1:0]       dec_unit;
  logic [2:0]       dec_md;
  logic             dec_ill;
  logic             accept;

`ifdef MULDIV_EN
  localparam logic [1:0] UNIT_MUL = 2'b01;
  localparam logic [1:0] UNIT_DIV = 2'b10;

  logic [3:0] cnt_reg;
  logic       div_start_reg;
  logic       div_abort_reg;

  assign div_start = div_start_reg;
  assign div_abort = div_abort_reg;
`else
  localparam int unused_mul_lat = MUL_LAT;
  logic unused_div_done;

  assign unused_div_done = div_done;
  assign div_start       = 1'b0;
  assign div_abort       = 1'b0;
`endif

  // Reset holds in_ready high; flush blocks acceptance in every state.
  // In OUT a new op can replace the current one in the same cycle it leaves.
  assign in_ready = rst | (~flush & ((state_reg == IDLE) |
                                     ((state_reg == OUT) & out_ready)));
  assign accept   = in_valid & in_ready;

  assign out_valid = out_valid_reg;
  assign alu_ctrl  = alu_ctrl_reg;
  assign unit_sel  = unit_sel_reg;
  assign md_op     = md_op_reg;
  assign illegal   = illegal_reg;
  assign tag_out   = tag_out_reg;

  // Field decode of the op presented on the input this cycle.
  always_comb begin
    dec_alu  = 4'b0000;
    dec_unit = 2'b00;
    dec_md   = 3'b000;
    dec_ill  = 1'b0;
    case (aluop)
      2'b01: begin
        case (funct3)
          3'b000:  dec_alu = 4'b0100;
          3'b001:  dec_alu = 4'b1100;
          3'b100:  dec_alu = 4'b0010;
          3'b101:  dec_alu = 4'b1010;
          3'b110:  dec_alu = 4'b0011;
          3'b111:  dec_alu = 4'b1011;
          default: begin
            dec_alu = 4'b0100;
            dec_ill = 1'b1;
          end
        endcase
      end
      2'b10: begin
        dec_alu = {funct7[5], funct3};
        if (is_imm) begin
          // For I-type only shift-right keeps funct7[5] as the
          // arithmetic/logical select; elsewhere it is an immediate bit.
          if (funct3 != 3'b101)
            dec_alu[3] = 1'b0;
          if ((funct3 == 3'b001 || funct3 == 3'b101) &&
              funct7 != F7_BASE && funct7 != F7_ALT)
            dec_ill = 1'b1;
        end else begin
          if (funct7 != F7_BASE && funct7 != F7_ALT && funct7 != F7_MULDIV)
            dec_ill = 1'b1;
          // Only SUB and SRA take the alternate funct7.
          if (funct7 == F7_ALT && funct3 != 3'b000 && funct3 != 3'b101)
            dec_ill = 1'b1;
          if (funct7 == F7_MULDIV) begin
`ifdef MULDIV_EN
            dec_alu  = 4'b0000;
            dec_md   = funct3;
            dec_unit = funct3[2] ? UNIT_DIV : UNIT_MUL;
`else
            dec_ill  = 1'b1;
`endif
          end
        end
      end
      2'b11:   dec_alu = 4'b1111;
      default: dec_alu = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      alu_ctrl_reg  <= 4'b0000;
      unit_sel_reg  <= 2'b00;
      md_op_reg     <= 3'b000;
      illegal_reg   <= 1'b0;
      tag_out_reg   <= '0;
`ifdef MULDIV_EN
      cnt_reg       <= 4'd0;
      div_start_reg <= 1'b0;
      div_abort_reg <= 1'b0;
`endif
    end else begin
`ifdef MULDIV_EN
      div_start_reg <= 1'b0;
      div_abort_reg <= 1'b0;
`endif
      if (flush) begin
        state_reg     <= IDLE;
        out_valid_reg <= 1'b0;
`ifdef MULDIV_EN
        cnt_reg       <= 4'd0;
        // A div_done arriving with the flush is simply dropped here.
        if (state_reg == DIV_WAIT)
          div_abort_reg <= 1'b1;
`endif
      end else if (accept) begin
        alu_ctrl_reg <= dec_alu;
        unit_sel_reg <= dec_unit;
        md_op_reg    <= dec_md;
        illegal_reg  <= dec_ill;
        tag_out_reg  <= tag_in;
`ifdef MULDIV_EN
        if (dec_unit == UNIT_MUL) begin
          state_reg     <= MUL_WAIT;
          cnt_reg       <= 4'(MUL_LAT - 1);
          out_valid_reg <= 1'b0;
        end else if (dec_unit == UNIT_DIV) begin
          state_reg     <= DIV_WAIT;
          div_start_reg <= 1'b1;
          out_valid_reg <= 1'b0;
        end else begin
          state_reg     <= OUT;
          out_valid_reg <= 1'b1;
        end
`else
        state_reg     <= OUT;
        out_valid_reg <= 1'b1;
`endif
      end else begin
        case (state_reg)
`ifdef MULDIV_EN
          MUL_WAIT: begin
            if (cnt_reg == 4'd0) begin
              state_reg     <= OUT;
              out_valid_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg - 4'd1;
            end
          end
          DIV_WAIT: begin
            // The start cycle may still see a stale done from the divider.
            if (!div_start_reg && div_done) begin
              state_reg     <= OUT;
              out_valid_reg <= 1'b1;
            end
          end
`endif
          OUT: begin
            if (out_ready) begin
              state_reg     <= IDLE;
              out_valid_reg <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
Parametrised, registered successor to the combinational ALU control decoder in the ID/EX boundary. Decodes ALUOp/funct3/funct7 into the 4-bit ALU control word and branch-compare encoding. Carries a destination tag alongside each operation. Sequences multi-cycle RV32M operations: a fixed-latency pipelined multiplier and an iterative divider driven by a start/done handshake. Uses a valid/ready handshake on both input and output so the pipeline stalls while a long operation is in flight.

Parameters:
MUL_LAT, 3, multiplier latency in cycles from accept to out_valid (legal range 1..15)
TAG_W, 5, width of pass-through destination tag (rd index)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  decoded instruction fields valid
in_ready  out  1  block can accept this cycle
aluop  in  2  00 ldst, 01 branch, 10 arithmetic, 11 jump
funct3  in  3  instruction funct3
funct7  in  7  instruction funct7
is_imm  in  1  I-type arithmetic (funct7 not an opcode extension except for shifts)
tag_in  in  TAG_W  destination tag
flush  in  1  pipeline flush, kills pending op
out_valid  out  1  result control word valid
out_ready  in  1  downstream accepts
alu_ctrl  out  4  ALU control {inverse, function}
unit_sel  out  2  00 ALU, 01 MUL, 10 DIV
md_op  out  3  funct3 of M op, else 000
illegal  out  1  undefined encoding
tag_out  out  TAG_W  tag of the op on the output
div_start  out  1  one-cycle pulse to divider
div_done  in  1  divider finished
div_abort  out  1  one-cycle pulse cancelling divider

Behaviour:
- Reset: state IDLE. All outputs 0 except in_ready=1. Counter=0. Reset overrides flush and all handshakes.
- Accept = in_valid & in_ready. Fields are captured into output registers on accept.
- Encodings (alu_ctrl):
  - ldst -> 0000 (ADD); jump -> 1111.
  - arithmetic -> {funct7[5], funct3}. Exception: is_imm=1 and funct3!=101 forces bit3=0.
  - branch: BEQ 000->0100, BNE 001->1100, BLT 100->0010, BGE 101->1010, BLTU 110->0011, BGEU 111->1011. funct3 010/011 -> 0100 with illegal=1.
  - arithmetic with funct7 not in {0000000, 0100000, 0000001} -> illegal=1. Also illegal when is_imm=0, funct7=0100000 and funct3 not in {000, 101}.
- M op: aluop=10, is_imm=0, funct7=0000001. funct3[2]=0 -> MUL, 1 -> DIV. For M ops: alu_ctrl=0000, md_op=funct3.
- States:
  - IDLE: in_ready=1. On accept, go to OUT (plain op), MUL_WAIT (cnt=MUL_LAT-1), or DIV_WAIT.
  - MUL_WAIT: in_ready=0. Counter decrements each cycle; at cnt=0 go to OUT. out_valid rises exactly MUL_LAT cycles after the accept edge (MUL_LAT=1 goes directly to OUT).
  - DIV_WAIT: in_ready=0. div_start=1 in its first cycle only. div_done is ignored while div_start=1, sampled afterwards. On div_done=1 go to OUT next cycle.
  - OUT: out_valid=1. Outputs held stable until out_ready. in_ready=out_ready. Accept while out_ready=1 loads the next op without a bubble, giving 1 op/cycle for plain ops.
- flush (any state): next state IDLE, out_valid=0, no accept that cycle (in_ready forced 0). If in DIV_WAIT, div_abort=1 for one cycle. A div_done coinciding with flush is discarded.
- div_done outside DIV_WAIT is ignored.
- unit_sel, md_op, tag_out are valid only while out_valid=1.

Optional Feature:
MULDIV_EN
- Defined: M-op sequencing as above.
- Undefined: MUL_WAIT/DIV_WAIT are removed. funct7=0000001 decodes as a plain op with alu_ctrl={0,funct3}, illegal=1, unit_sel=00. div_start and div_abort are tied 0; div_done is unused.

Test Plan:
- rst=1 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, div_start=0 throughout; first accept after release.
- Back-to-back: aluop=10, funct7=0100000, funct3=000, then is_imm=1 with the same fields, out_ready=1 -> alu_ctrl 1000 then 0000 on consecutive cycles, no bubble.
- aluop=01, funct3=101 -> alu_ctrl=1010, illegal=0. funct3=011 -> alu_ctrl=0100, illegal=1.
- MUL (funct7=0000001, funct3=000, tag 7), MUL_LAT=3 -> out_valid 3 cycles after accept, unit_sel=01, tag_out=7, in_ready=0 meanwhile.
- DIV (funct3=100), div_done after 10 cycles, out_ready held low 4 cycles -> single div_start pulse, outputs stable 4 cycles, in_ready=1 only when out_ready=1.
- DIV in flight, flush on cycle 5 together with div_done -> div_abort pulse, out_valid never asserted, IDLE next cycle.
